// File: rtl/sub86_ifetch_if.sv
// Core-side fetch and program-memory bus signals of the sub86 instruction fetch unit.
// master = fetch unit, slave = core/memory side.
interface sub86_ifetch_if;
   logic [31:0] IA;
   logic [15:0] ID;
   logic        HOLD;
   logic [31:0] MA;
   logic        MREQ;
   logic        MACK;
   logic [31:0] MD;

   modport master (input IA, MACK, MD, output ID, HOLD, MA, MREQ);
   modport slave  (output IA, MACK, MD, input ID, HOLD, MA, MREQ);
endinterface

// File: rtl/sub86_ifetch.sv
// sub86 instruction fetch/prefetch unit: word queue in front of a req/ack program memory.
// Define IFETCH_FWD_EN to forward MD straight to ID on the acknowledge cycle.
//
// state     | meaning
// S_IDLE    | no request outstanding; issue when queue has room or on redirect
// S_REQ     | request outstanding, its data goes to the queue tail
// S_DISCARD | request outstanding, its data is dropped (redirect arrived)
module sub86_ifetch #(
   parameter int DEPTH = 4
) (
   input logic             CLK,
   input logic             RST,
   sub86_ifetch_if.master  bus
);

   localparam int AW = $clog2(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
   localparam ptr_t PTR_ONE  = ptr_t'(1);

   state_t      state_q, state_d;
   logic        mreq_q, mreq_d;
   logic [29:0] ma_q, ma_d;
   logic [29:0] fp_q, fp_d;
   logic [29:0] tag_q, tag_d;
   ptr_t        rd_q, rd_d;
   cnt_t        cnt_q, cnt_d;
   logic [31:0] mem_q [DEPTH];
   logic [31:0] mem_d [DEPTH];

   logic [29:0] ia_w;
   logic [29:0] off;
   logic        hit, adv, pend, redirect, ack, fwd;
   logic        wr_en, do_issue;
   logic [29:0] issue_w;
   ptr_t        wr_idx, sel_idx;
   logic [31:0] sel_word, src_word;
   logic [15:0] hw;
   logic        unused_ia0;

   assign unused_ia0 = bus.IA[0];
   assign ia_w       = bus.IA[31:2];
   assign off        = ia_w - tag_q;
   assign ack        = mreq_q && bus.MACK;

   assign hit = (cnt_q != '0) && (off == '0);
   assign adv = (cnt_q > cnt_t'(1)) && (off == 30'd1);

   // Not yet in the queue, but it is exactly the word already on its way:
   // wait for it rather than flushing.
   assign pend = (state_q != S_IDLE) &&
                 (((cnt_q == '0) && (off == '0)) ||
                  ((cnt_q == cnt_t'(1)) && (state_q == S_REQ) && (off == 30'd1)));

   assign redirect = !hit && !adv && !pend;

`ifdef IFETCH_FWD_EN
   assign fwd = !hit && !adv && (state_q == S_REQ) && ack && (ma_q == ia_w);
`else
   assign fwd = 1'b0;
`endif

   assign wr_idx   = rd_q + cnt_q[AW-1:0];
   assign sel_idx  = adv ? (rd_q + PTR_ONE) : rd_q;
   assign sel_word = mem_q[sel_idx];
   assign src_word = fwd ? bus.MD : sel_word;
   assign hw       = bus.IA[1] ? src_word[31:16] : src_word[15:0];

   assign bus.HOLD = !(hit || adv || fwd);
   assign bus.ID   = (hit || adv || fwd) ? {hw[7:0], hw[15:8]} : 16'h0000;
   assign bus.MA   = {ma_q, 2'b00};
   assign bus.MREQ = mreq_q;

   always_comb begin
      state_d  = state_q;
      mreq_d   = mreq_q;
      ma_d     = ma_q;
      fp_d     = fp_q;
      tag_d    = tag_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      wr_en    = 1'b0;
      do_issue = 1'b0;
      issue_w  = fp_q;

      if (redirect) begin
         cnt_d = '0;
         tag_d = ia_w;
      end else begin
         wr_en = (state_q == S_REQ) && ack;
         if (wr_en) mem_d[wr_idx] = bus.MD;
         cnt_d = cnt_q + cnt_t'(wr_en) - cnt_t'(adv);
         if (adv) begin
            rd_d  = rd_q + PTR_ONE;
            tag_d = tag_q + 30'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               do_issue = 1'b1;
               issue_w  = ia_w;
            end else if (cnt_q < CNT_FULL) begin
               do_issue = 1'b1;
            end
         end
         S_REQ: begin
            if (redirect) begin
               if (ack) begin
                  do_issue = 1'b1;
                  issue_w  = ia_w;
               end else begin
                  state_d = S_DISCARD;
                  fp_d    = ia_w;
               end
            end else if (ack) begin
               if (cnt_d < CNT_FULL) begin
                  do_issue = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  mreq_d  = 1'b0;
               end
            end
         end
         S_DISCARD: begin
            if (ack) begin
               do_issue = 1'b1;
               issue_w  = redirect ? ia_w : fp_q;
            end else if (redirect) begin
               fp_d = ia_w;
            end
         end
         default: begin
            state_d = S_IDLE;
            mreq_d  = 1'b0;
         end
      endcase

      if (do_issue) begin
         state_d = S_REQ;
         mreq_d  = 1'b1;
         ma_d    = issue_w;
         fp_d    = issue_w + 30'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         mreq_q  <= 1'b0;
         ma_q    <= '0;
         fp_q    <= '0;
         tag_q   <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         mreq_q  <= mreq_d;
         ma_q    <= ma_d;
         fp_q    <= fp_d;
         tag_q   <= tag_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: tb/tb_sub86_ifetch.sv
// Directed bench for sub86_ifetch: behavioural program memory with programmable
// wait states, MA and ID scoreboards, and a per-cycle opcode monitor.
module tb_sub86_ifetch;

   logic clk;
   logic rst;
   sub86_ifetch_if bus ();

   sub86_ifetch #(.DEPTH(4)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int          n_err;
   int          n_checks;
   int          lat;
   int          wcnt;
   int          ack_cnt;
   logic        prev_held;
   logic [31:0] prev_ma;
   logic [31:0] ma_exp [$];
   logic [15:0] id_exp [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h0F84E990;
   endfunction

   function automatic logic [15:0] exp_id(input logic [31:0] ia);
      logic [31:0] w;
      logic [15:0] h;
      w = mem_word({ia[31:2], 2'b00});
      h = ia[1] ? w[31:16] : w[15:0];
      return {h[7:0], h[15:8]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Program memory: acknowledges lat cycles after MREQ rises, data in the ack cycle.
   assign bus.MACK = bus.MREQ && (wcnt == lat);
   assign bus.MD   = mem_word(bus.MA);

   always @(posedge clk or posedge rst) begin
      if (rst)                          wcnt <= 0;
      else if (bus.MREQ && !bus.MACK)   wcnt <= wcnt + 1;
      else                              wcnt <= 0;
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_held <= 1'b0;
      end else begin
         if (prev_held) begin
            chk("mreq_held", {31'd0, bus.MREQ}, 32'd1);
            chk("ma_stable", bus.MA, prev_ma);
         end
         if (bus.MREQ && bus.MACK) begin
            ack_cnt <= ack_cnt + 1;
            if (ma_exp.size() > 0) chk("ma_order", bus.MA, ma_exp.pop_front());
         end
         if (!bus.HOLD) chk("id_stream", {16'd0, bus.ID}, {16'd0, exp_id(bus.IA)});
         prev_held <= bus.MREQ && !bus.MACK;
         prev_ma   <= bus.MA;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int l);
      rst = 1'b1;
      lat = l;
      ma_exp.delete();
      id_exp.delete();
      ack_cnt = 0;
      step();
   endtask

   task automatic fetch(input logic [31:0] ia, input int budget, output int waited);
      logic [15:0] e;
      bus.IA = ia;
      id_exp.push_back(exp_id(ia));
      waited = 0;
      #1;
      while (bus.HOLD !== 1'b0 && waited < budget) begin
         step();
         waited++;
      end
      e = id_exp.pop_front();
      chk("fetch_hold", {31'd0, bus.HOLD}, 32'd0);
      chk("fetch_id", {16'd0, bus.ID}, {16'd0, e});
   endtask

   int w;
   int k;

   initial begin
      n_err = 0;
      n_checks = 0;
      bus.IA = 32'h0;
      rst = 1'b1;

      // Basic fetch
      do_reset(0);
      chk("rst_hold", {31'd0, bus.HOLD}, 32'd1);
      chk("rst_mreq", {31'd0, bus.MREQ}, 32'd0);
      chk("rst_ma", bus.MA, 32'h0);
      chk("rst_id", {16'd0, bus.ID}, 32'h0);
      ma_exp.push_back(32'h0);
      ma_exp.push_back(32'h4);
      ma_exp.push_back(32'h8);
      ma_exp.push_back(32'hC);
      rst = 1'b0;
      step();
      chk("basic_c1_mreq", {31'd0, bus.MREQ}, 32'd1);
      chk("basic_c1_ma", bus.MA, 32'h0);
      step();
      chk("basic_c2_hold", {31'd0, bus.HOLD}, 32'd0);
      chk("basic_c2_id", {16'd0, bus.ID}, 32'h90E9);
      bus.IA = 32'h2;
      #1;
      chk("basic_ia2_id", {16'd0, bus.ID}, 32'h840F);
      chk("basic_ia2_hold", {31'd0, bus.HOLD}, 32'd0);
      step();
      chk("basic_ia2_noredir", {31'd0, bus.HOLD}, 32'd0);

      // Streaming
      do_reset(0);
      for (int i = 0; i < 16; i++) ma_exp.push_back(32'(i * 4));
      bus.IA = 32'h0;
      rst = 1'b0;
      for (int a = 0; a <= 32'h3E; a += 2) begin
         fetch(32'(a), 20, w);
         if (a >= 4) chk("stream_nohold", 32'(w), 32'd0);
         step();
      end

      // Wait states
      do_reset(3);
      ma_exp.push_back(32'h0);
      bus.IA = 32'h0;
      rst = 1'b0;
      step();
      chk("ws_mreq", {31'd0, bus.MREQ}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("ws_ma", bus.MA, 32'h0);
         chk("ws_hold", {31'd0, bus.HOLD}, 32'd1);
      end
      step();
      chk("ws_mack", {31'd0, bus.MACK}, 32'd1);
`ifdef IFETCH_FWD_EN
      chk("ws_ack_hold", {31'd0, bus.HOLD}, 32'd0);
`else
      chk("ws_ack_hold", {31'd0, bus.HOLD}, 32'd1);
`endif
      step();
      chk("ws_done_hold", {31'd0, bus.HOLD}, 32'd0);
      chk("ws_done_id", {16'd0, bus.ID}, {16'd0, exp_id(32'h0)});

      // Redirect with an outstanding request
      do_reset(3);
      ma_exp.push_back(32'h0);
      ma_exp.push_back(32'h4);
      ma_exp.push_back(32'h8);
      ma_exp.push_back(32'h100);
      ma_exp.push_back(32'h104);
      bus.IA = 32'h0;
      rst = 1'b0;
      fetch(32'h0, 20, w);
      k = 0;
      while (!(bus.MREQ && bus.MA == 32'h8) && k < 30) begin
         step();
         k++;
      end
      chk("redir_pending_ma", bus.MA, 32'h8);
      chk("redir_pending_nack", {31'd0, bus.MACK}, 32'd0);
      bus.IA = 32'h100;
      #1;
      chk("redir_hold", {31'd0, bus.HOLD}, 32'd1);
      fetch(32'h100, 30, w);
      step();
      fetch(32'h102, 5, w);
      chk("redir_ma_left", 32'(ma_exp.size()), 32'd1);

      // Queue full
      do_reset(0);
      ma_exp.push_back(32'h0);
      ma_exp.push_back(32'h4);
      ma_exp.push_back(32'h8);
      ma_exp.push_back(32'hC);
      ma_exp.push_back(32'h10);
      bus.IA = 32'h0;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("full_acks", 32'(ack_cnt), 32'd4);
      chk("full_mreq", {31'd0, bus.MREQ}, 32'd0);
      bus.IA = 32'h4;
      k = 0;
      while (!bus.MREQ && k < 5) begin
         step();
         k++;
      end
      chk("full_refill_mreq", {31'd0, bus.MREQ}, 32'd1);
      chk("full_refill_ma", bus.MA, 32'h10);

      // Reset during REQ
      do_reset(3);
      bus.IA = 32'h40;
      rst = 1'b0;
      step();
      chk("rreq_mreq", {31'd0, bus.MREQ}, 32'd1);
      chk("rreq_ma", bus.MA, 32'h40);
      #2;
      rst = 1'b1;
      #1;
      chk("rreq_mreq_drop", {31'd0, bus.MREQ}, 32'd0);
      chk("rreq_ma_clr", bus.MA, 32'h0);
      chk("rreq_hold", {31'd0, bus.HOLD}, 32'd1);
      chk("rreq_id", {16'd0, bus.ID}, 32'h0);
      ma_exp.delete();
      ma_exp.push_back(32'h80);
      step();
      rst = 1'b0;
      fetch(32'h80, 20, w);
      chk("rreq_ma_left", 32'(ma_exp.size()), 32'd0);

      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/sub86_ifetch.md
# sub86_ifetch

Instruction fetch and prefetch unit sitting directly upstream of the sub86 core. It turns the core's halfword instruction address (IA) into a 16-bit opcode stream (ID) fetched from a 32-bit program memory over a req/ack handshake. A small word queue hides memory latency on sequential code. HOLD tells the top level to freeze the core whenever the requested halfword is not yet available.

## Interface
- DEPTH, 4, prefetch queue depth in 32-bit words; power of two, at least 2.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IA  in  32  core fetch byte address; always even, and IA[0] is ignored.
- ID  out  16  opcode for IA in core byte order; valid only while HOLD=0.
- HOLD  out  1  high when the halfword at IA is unavailable; top level freezes core state and IA while high.
- MA  out  32  program memory word address; MA[1:0] is always 00.
- MREQ  out  1  memory read request.
- MACK  in  1  memory acknowledge; MD is valid in the same cycle.
- MD  in  32  memory read data, little-endian.

## Operation
- Queue holds up to DEPTH words at consecutive word addresses; the head tag is the word address of the oldest entry.
- Halfword select: IA[1]=0 selects hw=MD[15:0]; IA[1]=1 selects hw=MD[31:16]. ID={hw[7:0],hw[15:8]}.
- Hit: head is valid and IA[31:2]==head tag. ID comes from the head entry and HOLD=0.
- Advance: IA[31:2]==head tag+1 and entry 1 is valid. Pop the head at the clock edge; the combinational ID comes from entry 1 and HOLD=0.
- Redirect: any IA that is neither a hit nor an advance.
  - HOLD=1.
  - Flush the queue at the edge.
  - Set the fetch pointer to IA[31:2].
  - Covers jumps, call/ret and the first fetch after reset.
- Fetch FSM states:
  - IDLE: issue when (valid count + outstanding) < DEPTH, or on redirect. Go to REQ and drive MA=fetch pointer<<2.
  - REQ: MREQ=1 and MA held stable until MACK=1.
    - On MACK, write MD to the queue tail (or drop it, see DISCARD) and increment the fetch pointer.
    - Back-to-back: stay in REQ with the next MA if space remains, otherwise go to IDLE.
  - DISCARD: a redirect arrived while in REQ. MREQ and MA stay held (a request is never withdrawn). On MACK, drop MD, then issue the redirect target the next cycle.
- At most one request is outstanding.
- Word address arithmetic is 30-bit and wraps from 0x3FFFFFFF to 0.
- Queue full: no MREQ until a pop. A simultaneous pop and MACK write is allowed when full.
- Simultaneous redirect and MACK in the same cycle: drop MD and issue the new target next cycle.

## Timing
- Reset values: HOLD=1, MREQ=0, MA=0, ID=0; queue empty; FSM in IDLE.
- Reset mid-transaction: MREQ drops immediately (asynchronous). Memory must tolerate a dropped request during reset.
- Redirect in cycle N with a zero-wait memory:
  - MREQ asserted in cycle N+1.
  - Data written at the end of N+1.
  - HOLD=0 in cycle N+2, giving a 2-cycle penalty.
  - Each memory wait state adds one cycle. A pending DISCARD adds its own remaining latency.
- Sequential code with zero-wait memory: HOLD stays low after the first word. One MREQ is issued per two IA steps.
- MREQ and MA are registered outputs. ID and HOLD are combinational from IA and the queue (plus MD when forwarding is compiled in).

## Configuration
- Macro IFETCH_FWD_EN.
- Defined: when MACK=1 and MA[31:2]==IA[31:2] in a redirect/refill cycle, ID comes directly from MD and HOLD=0 that cycle. The word is still written to the queue. Redirect penalty drops to 1 cycle.
- Undefined: no MD-to-ID path; data is usable only from the queue, the cycle after the write.

## Test plan
- Basic fetch: word 0 = 0x0F84E990, zero-wait memory, release RST with IA=0.
  - MREQ with MA=0 in cycle 1.
  - Cycle 2: ID=16'h90E9 and HOLD=0.
  - With IA=2: ID=16'h840F and no new redirect.
- Streaming: IA increments by 2 each cycle from 0 to 0x3E with zero-wait memory. After the initial fill, HOLD=0 every cycle and MA steps 0x4, 0x8, … in order.
- Wait states: MACK returns 3 cycles after MREQ. MA is stable throughout, HOLD=1 until the MACK cycle+1, then the correct ID appears.
- Redirect with an outstanding request: IA jumps to 0x100 while MA=0x8 is pending.
  - Data at 0x8 is discarded.
  - Next MREQ has MA=0x100.
  - ID equals the byte-swapped halfword at 0x100.
  - No stale opcode ever appears with HOLD=0.
- Queue full: IA held at 0 (core in mul) for 20 cycles. Exactly DEPTH=4 requests are issued (MA 0x0–0xC), then MREQ=0. Releasing IA to 4 triggers the next request with MA=0x10.
- Reset during REQ: assert RST while MREQ=1. MREQ, MA and HOLD take their reset values immediately, and re-fetch starts from IA after release.
